// File: rtl/kf_pkg.sv
// Shared FSM state type and saturation helper for the covariance prediction engine.
package kf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MUL1,
        MUL2,
        SYM,
        DONE
    } kf_state_e;

    // Wide enough for any accumulator the engine can be built with.
    localparam int CLIP_W = 64;

    function automatic logic signed [CLIP_W-1:0] sat_clip(
        input logic signed [CLIP_W-1:0] x,
        input int                       w
    );
        logic signed [CLIP_W-1:0] hi;
        logic signed [CLIP_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/kf_mac_sat.sv
// Signed multiply-accumulate with floor shift by FRAC and saturation to WIDTH bits.
module kf_mac_sat
    import kf_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int ACCW  = 2 * WIDTH + 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    first,
    input  logic signed [WIDTH-1:0] bias,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] result,
    output logic                    sat
);

    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACCW-1:0]    bias_ext;
    logic signed [ACCW-1:0]    prod_ext;
    logic signed [ACCW-1:0]    base;
    logic signed [ACCW-1:0]    sum;
    logic signed [ACCW-1:0]    shifted;
    logic signed [ACCW-1:0]    acc_q;
    logic signed [CLIP_W-1:0]  wide;
    logic signed [CLIP_W-1:0]  clipped;

    assign a_ext    = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_ext    = {{WIDTH{b[WIDTH-1]}}, b};
    assign prod     = a_ext * b_ext;
    assign prod_ext = {{(ACCW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
    assign bias_ext = {{(ACCW-WIDTH){bias[WIDTH-1]}}, bias};

    // The first product of each element starts from the bias, aligned to the product's binary point.
    assign base    = first ? (bias_ext <<< FRAC) : acc_q;
    assign sum     = base + prod_ext;
    assign shifted = sum >>> FRAC;
    assign wide    = {{(CLIP_W-ACCW){shifted[ACCW-1]}}, shifted};
    assign clipped = sat_clip(wide, WIDTH);
    assign sat     = (clipped != wide);
    assign result  = clipped[WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= sum;
        end
    end

endmodule

// File: rtl/cov_predict_engine.sv
// Covariance prediction P <= A P A^T + Q using one time-shared MAC, with optional symmetrization.
module cov_predict_engine
    import kf_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int FRAC   = 8,
    parameter int NOS    = 4,
    parameter int SYM_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             load_p0,
    input  logic [WIDTH-1:0] A  [0:NOS-1][0:NOS-1],
    input  logic [WIDTH-1:0] Q  [0:NOS-1][0:NOS-1],
    input  logic [WIDTH-1:0] P0 [0:NOS-1][0:NOS-1],
    output logic [WIDTH-1:0] P  [0:NOS-1][0:NOS-1],
    output logic             busy,
    output logic             done,
    output logic             sat_flag
);

    localparam int CW   = $clog2(NOS);
    localparam int ACCW = 2 * WIDTH + CW + 1;
    localparam logic [CW-1:0] LAST = CW'(NOS - 1);

    kf_state_e state;
    logic [CW-1:0] i, j, k;
    logic [WIDTH-1:0] p_r  [0:NOS-1][0:NOS-1];
    logic [WIDTH-1:0] t_r  [0:NOS-1][0:NOS-1];
    logic [WIDTH-1:0] pn_r [0:NOS-1][0:NOS-1];
    logic [WIDTH-1:0] sym_p[0:NOS-1][0:NOS-1];

    logic                    mac_en;
    logic                    mac_first;
    logic                    mac_last;
    logic signed [WIDTH-1:0] op_a;
    logic signed [WIDTH-1:0] op_b;
    logic signed [WIDTH-1:0] bias;
    logic signed [WIDTH-1:0] mac_res;
    logic                    mac_sat;

    assign P         = p_r;
    assign mac_first = (k == '0);
    assign mac_last  = (k == LAST);

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        mac_en = 1'b0;
        op_a   = '0;
        op_b   = '0;
        bias   = '0;
        case (state)
            MUL1: begin
                mac_en = 1'b1;
                op_a   = A[i][k];
                op_b   = p_r[k][j];
            end
            MUL2: begin
                mac_en = 1'b1;
                op_a   = t_r[i][k];
                op_b   = A[j][k];
                bias   = Q[i][j];
            end
            default: ;
        endcase
    end

    // Averaging at WIDTH+1 bits cannot overflow, so no saturation is needed here.
    always_comb begin
        sym_p = pn_r;
        if (SYM_EN != 0) begin
            for (int r = 0; r < NOS; r++) begin
                for (int c = 0; c < NOS; c++) begin
                    sym_p[r][c] = WIDTH'(($signed({pn_r[r][c][WIDTH-1], pn_r[r][c]})
                                        + $signed({pn_r[c][r][WIDTH-1], pn_r[c][r]})) >>> 1);
                end
            end
        end
    end

    kf_mac_sat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .ACCW  (ACCW)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .en     (mac_en),
        .first  (mac_first),
        .bias   (bias),
        .a      (op_a),
        .b      (op_b),
        .result (mac_res),
        .sat    (mac_sat)
    );

    // NOTE: state updates use non-blocking assignments; the matrix registers are reset too so an aborted prediction leaves P cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sat_flag <= 1'b0;
            p_r      <= '{default: '0};
            t_r      <= '{default: '0};
            pn_r     <= '{default: '0};
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_p0) begin
                        p_r <= P0;
                    end else if (start) begin
                        state    <= MUL1;
                        busy     <= 1'b1;
                        sat_flag <= 1'b0;
                        i        <= '0;
                        j        <= '0;
                        k        <= '0;
                    end
                end
                MUL1, MUL2: begin
                    if (mac_last) begin
                        if (mac_sat) sat_flag <= 1'b1;
                        if (state == MUL1) t_r[i][j]  <= mac_res;
                        else               pn_r[i][j] <= mac_res;
                        k <= '0;
                        if (j == LAST) begin
                            j <= '0;
                            if (i == LAST) begin
                                i     <= '0;
                                state <= (state == MUL1) ? MUL2 : SYM;
                            end else begin
                                i <= i + 1'b1;
                            end
                        end else begin
                            j <= j + 1'b1;
                        end
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                SYM: begin
                    p_r   <= sym_p;
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
